// File: rtl/btn_event_bank.sv
// ============================================================================
// btn_event_bank : 2-FF sync, tick debounce and one-key arbitration for NUM_BTN buttons.
// Optional AUTO_REPEAT_EN macro adds held-key auto-repeat.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module btn_event_bank #(
  parameter int NUM_BTN      = 7,
  parameter int DEB_TICKS    = 3,
  parameter int CODE_W       = 3,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press,
  output logic [CODE_W-1:0]  key_code,
  output logic               any_held
);

  localparam int c_CNT_W = (DEB_TICKS < 2) ? 1 : $clog2(DEB_TICKS + 1);

  if (DEB_TICKS < 1 || (1 << CODE_W) <= NUM_BTN || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
  begin : g_param_check
    $error("btn_event_bank: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d, level_dly_q;
  logic [c_CNT_W-1:0] cnt_q [NUM_BTN];
  logic [c_CNT_W-1:0] cnt_d [NUM_BTN];

  state_t             state_q, state_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] acc_q, acc_d;
  logic [CODE_W-1:0]  code_q, code_d;

  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_sel_oh;
  logic [CODE_W-1:0]  w_sel_code;
  logic               w_acc_level;
  logic               w_other_held;

`ifdef AUTO_REPEAT_EN
  localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

  logic [c_REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic               rep_phase_q, rep_phase_d;
  logic [c_REP_W-1:0] w_rep_next;
  logic [c_REP_W-1:0] w_rep_target;

  assign w_rep_next   = rep_cnt_q + c_REP_W'(1);
  assign w_rep_target = rep_phase_q ? c_REP_W'(REPEAT_RATE) : c_REP_W'(REPEAT_DELAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`endif

  // Debounce: a level flips only after DEB_TICKS consecutive disagreeing ticks.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != level_q[i]) begin
          if (cnt_q[i] == c_CNT_W'(DEB_TICKS - 1)) begin
            level_d[i] = ~level_q[i];
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + c_CNT_W'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign w_rise       = level_q & ~level_dly_q;
  assign w_acc_level  = |(level_q & acc_q);
  assign w_other_held = |(level_q & ~acc_q);

  // Descending scan so the lowest simultaneous rise wins.
  always_comb begin
    w_sel_oh   = '0;
    w_sel_code = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
        w_sel_code  = CODE_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    press_d = '0;
    acc_d   = acc_q;
    code_d  = code_q;
`ifdef AUTO_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (|w_rise) begin
          press_d = w_sel_oh;
          acc_d   = w_sel_oh;
          code_d  = w_sel_code;
          state_d = HELD;
`ifdef AUTO_REPEAT_EN
          rep_cnt_d   = '0;
          rep_phase_d = 1'b0;
`endif
        end
      end
      HELD: begin
        if (!w_acc_level) begin
          acc_d   = '0;
          code_d  = '0;
          state_d = w_other_held ? LOCKOUT : IDLE;
        end
`ifdef AUTO_REPEAT_EN
        else if (tick) begin
          if (w_rep_next == w_rep_target) begin
            press_d     = acc_q;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
          end else begin
            rep_cnt_d = w_rep_next;
          end
        end
`endif
      end
      LOCKOUT: begin
        if (level_q == '0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      press_q <= '0;
      acc_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      acc_q   <= acc_d;
      code_q  <= code_d;
    end
  end

  assign btn_level = level_q;
  assign press     = press_q;
  assign key_code  = code_q;
  assign any_held  = |level_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_event_bank.sv
// ============================================================================
// tb_btn_event_bank : directed, table-driven self-checking bench with tick tied high.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_btn_event_bank;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b1;
  logic [6:0] btn_raw = '0;
  logic [6:0] btn_level;
  logic [6:0] press;
  logic [2:0] key_code;
  logic       any_held;

  int checks = 0;
  int errors = 0;

  btn_event_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .press     (press),
    .key_code  (key_code),
    .any_held  (any_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] raw;
    logic [6:0] lvl;
    logic [6:0] prs;
    logic [2:0] code;
    logic       any;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [6:0] lvl, input logic [6:0] prs,
                         input logic [2:0] code, input logic any);
    chk({name, ".level"}, 32'(btn_level), 32'(lvl));
    chk({name, ".press"}, 32'(press), 32'(prs));
    chk({name, ".code"},  32'(key_code), 32'(code));
    chk({name, ".any"},   32'(any_held), 32'(any));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reps;
    int exp_reps;

    for (int i = 0; i < 13; i++) begin
      vecs[i].raw  = (i < 7) ? 7'b0000100 : 7'b0000000;
      vecs[i].prs  = 7'b0000000;
      vecs[i].lvl  = (i >= 4 && i <= 10) ? 7'b0000100 : 7'b0000000;
      vecs[i].any  = (i >= 4 && i <= 10);
      vecs[i].code = (i >= 5 && i <= 11) ? 3'd3 : 3'd0;
    end
    vecs[5].prs = 7'b0000100;

    steps(2);
    chk_all("reset", 7'd0, 7'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
    steps(3);
    chk_all("idle", 7'd0, 7'd0, 3'd0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      btn_raw = vecs[i].raw;
      step();
      chk_all($sformatf("clean[%0d]", i), vecs[i].lvl, vecs[i].prs, vecs[i].code, vecs[i].any);
    end

    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        btn_raw = (c < 2) ? 7'b0000001 : 7'b0000000;
        step();
        chk_all($sformatf("bounce[%0d.%0d]", r, c), 7'd0, 7'd0, 3'd0, 1'b0);
      end
    end
    steps(4);
    chk_all("bounce_end", 7'd0, 7'd0, 3'd0, 1'b0);

    btn_raw = 7'b0101000;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("simul_pre[%0d]", c), 32'(press), 32'd0);
    end
    step();
    chk_all("simul_accept", 7'b0101000, 7'b0001000, 3'd4, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("simul_nopress[%0d]", c), 32'(press), 32'd0);
    end
    chk("simul_code_held", 32'(key_code), 32'd4);
    btn_raw = 7'b0000000;
    steps(8);
    chk_all("simul_release", 7'd0, 7'd0, 3'd0, 1'b0);

    btn_raw = 7'b0000010;
    steps(6);
    chk_all("lock_accept1", 7'b0000010, 7'b0000010, 3'd2, 1'b1);
    btn_raw = 7'b0010010;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("lock_add4[%0d]", c), 32'(press), 32'd0);
    end
    chk("lock_code_still2", 32'(key_code), 32'd2);
    btn_raw = 7'b0010000;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("lock_rel1[%0d]", c), 32'(press), 32'd0);
    end
    chk_all("lockout", 7'b0010000, 7'd0, 3'd0, 1'b1);
    btn_raw = 7'b0000000;
    steps(8);
    chk_all("lock_rel4", 7'd0, 7'd0, 3'd0, 1'b0);
    btn_raw = 7'b0010000;
    steps(5);
    chk("lock_repress_pre", 32'(press), 32'd0);
    step();
    chk_all("lock_repress4", 7'b0010000, 7'b0010000, 3'd5, 1'b1);
    step();
    chk("lock_repress_1cyc", 32'(press), 32'd0);
    btn_raw = 7'b0000000;
    steps(8);

    btn_raw = 7'b0000010;
    steps(6);
    chk_all("rst_hold_accept", 7'b0000010, 7'b0000010, 3'd2, 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 7'd0, 7'd0, 3'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("rst_redeb[%0d]", c), 32'(press), 32'd0);
    end
    step();
    chk_all("rst_repress", 7'b0000010, 7'b0000010, 3'd2, 1'b1);
    btn_raw = 7'b0000000;
    steps(8);

    reps = 0;
`ifdef AUTO_REPEAT_EN
    exp_reps = 5;
`else
    exp_reps = 1;
`endif
    btn_raw = 7'b1000000;
    for (int c = 0; c < 37; c++) begin
      step();
      if (press == 7'b1000000) reps++;
    end
    chk("repeat_code", 32'(key_code), 32'd7);
    chk("repeat_count", 32'(reps), 32'(exp_reps));
    btn_raw = 7'b0000000;
    steps(8);
    chk_all("final_idle", 7'd0, 7'd0, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/btn_event_bank.md
Name: btn_event_bank

Overview:
- Front-end stage for the dice counter logic.
- Synchronises and debounces NUM_BTN raw push-buttons using the shared 32 Hz tick strobe.
- Arbitrates them so that only one key is accepted at a time.
- Emits a single-cycle one-hot press event plus a held-key code, which the digit counter consumes directly.

Parameters:
- NUM_BTN, 7: number of button inputs.
- DEB_TICKS, 3: consecutive ticks of stable opposite level needed to flip a debounced level. Minimum 1.
- CODE_W, 3: width of key_code. Must satisfy 2^CODE_W > NUM_BTN.
- REPEAT_DELAY, 16: ticks from acceptance to the first auto-repeat. Used only with AUTO_REPEAT_EN.
- REPEAT_RATE, 4: ticks between subsequent auto-repeats. Used only with AUTO_REPEAT_EN.

Ports:
- clk, input, 1: system clock, 32768 Hz, posedge.
- rst_n, input, 1: reset, asynchronous assert, active-low. All state clears while low.
- tick, input, 1: one-cycle strobe at 32 Hz from the prescaler.
- btn_raw, input, NUM_BTN: raw active-high buttons, asynchronous to clk.
- btn_level, output, NUM_BTN: debounced levels.
- press, output, NUM_BTN: one-hot or all-zero, one-cycle accepted-press pulse.
- key_code, output, CODE_W: index+1 of the accepted key while it is held; 0 when no key is accepted.
- any_held, output, 1: OR of btn_level. Used for display blanking.

Behaviour:
- Reset values: btn_level=0, press=0, key_code=0, any_held=0, FSM=IDLE, all debounce counters=0, synchronisers=0.
- Synchronisation: 2-FF synchroniser per input on posedge clk. Raw-to-sync latency is 2 cycles.
- Debounce, per button:
  - Counter advances only on tick cycles.
  - On a tick where sync != btn_level: cnt += 1. When cnt reaches DEB_TICKS, btn_level toggles and cnt clears, both on that same tick edge.
  - On a tick where sync == btn_level: cnt clears.
  - Between ticks, cnt holds.
  - Any glitch shorter than DEB_TICKS consecutive ticks never changes btn_level.
- Edge detect: rise[i] = btn_level[i] & ~btn_level_d[i], where btn_level_d is a 1-cycle delayed copy.
- any_held is combinational from btn_level.
- Arbitration FSM states: IDLE, HELD, LOCKOUT.
  - IDLE: if any rise[i], select the lowest index i among simultaneous rises, pulse press[i] for the next cycle, set key_code=i+1, go to HELD. Levels that are already high without a rise are ignored.
  - HELD: rises on other buttons are ignored (no press). When btn_level of the accepted key goes 0: clear key_code; go to LOCKOUT if any other level is still 1, else go to IDLE.
  - LOCKOUT: no events. Go to IDLE when any_held==0.
- Latency: press is asserted exactly 1 cycle after the btn_level rising edge and lasts exactly 1 cycle.
- key_code updates in the same cycle press asserts and clears in the cycle after the accepted level falls.
- Mid-operation reset: everything clears immediately. A button held through reset debounces to 1 again after DEB_TICKS ticks and then produces a new press.
- tick held high continuously is legal. Debounce then counts every cycle, which is used for fast simulation.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- When defined:
  - In HELD, a repeat counter counts ticks from acceptance.
  - After REPEAT_DELAY ticks, press[i] for the accepted key re-pulses for one cycle.
  - It then re-pulses every REPEAT_RATE ticks until the key is released.
  - key_code is unchanged by repeats.
  - The counter clears on entering HELD and on reset.
- When undefined: exactly one press pulse per accepted key-down, and no repeat counter hardware.

Test Plan:
- Bench setup: tick tied high for all scenarios.
- Clean press: btn_raw[2] 0→1 → btn_level[2]=1 after 2 sync cycles + 3 ticks; press=0000100 for 1 cycle the following cycle; key_code=3 while held; key_code=0 after release.
- Bounce rejection: btn_raw[0] toggles high for 2 ticks then low, repeated 5 times → btn_level, press and key_code stay 0 throughout.
- Simultaneous press: btn_raw[5] and btn_raw[3] rise on the same cycle → single press=0001000, key_code=4; no press for button 5.
- Lockout: hold btn 1, then add btn 4, then release btn 1 → no press for btn 4, state LOCKOUT; release btn 4 and press it again → press[4] pulses and key_code=5.
- Reset mid-hold: assert rst_n=0 while key_code=2 → all outputs 0 immediately; release reset with btn 1 still held → press[1] fires again after debounce.
- AUTO_REPEAT_EN: hold btn 6 for 30 ticks → press[6] pulses at acceptance, at tick 16, and at tick 20, 24 and 28 (5 pulses total); without the macro, 1 pulse.
